dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the processor's load/store stage. It accepts one load or store request at a time over a valid/ready handshake, holds it for a configurable access latency, then commits the store or reads the word. It returns the result over a valid/ready response channel, with sign or zero extension and an error flag. It replaces the inline data array: the memory-access stage becomes the initiator, and this block is the memory end of the same interface.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array. Byte capacity is DEPTH_WORDS*4.
- LATENCY, 1: wait cycles between accept and response. Legal range 0..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE and while rst is low.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  BIN_DIG  byte address.
- req_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal and sets the error flag.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0 (LBU/LHU vs LB/LH).
- req_wdata  in  BIN_DIG  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator takes the response.
- rsp_rdata  out  BIN_DIG  load result after extension; 0 for stores and for errors.
- rsp_err  out  1  access rejected; memory is unchanged.

## Operation
- Storage: DEPTH_WORDS x 32 array, little-endian.
  - Word index = req_addr[..:2].
  - Byte lane = req_addr[1:0].
  - Contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid, capture all request fields. Go to WAIT if LATENCY > 0, otherwise go to RESP.
  - WAIT: the 4-bit counter loads LATENCY-1 on accept and decrements each cycle. When the counter reaches 0, perform the access and go to RESP.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready, then go to IDLE.
- Error conditions:
  - Byte address >= DEPTH_WORDS*4.
  - req_size = 11.
  - Misalignment, as defined under Configuration.
- Errored store: no write, rsp_err = 1.
- Errored load: rsp_rdata = 0, rsp_err = 1.
- Store:
  - Byte: writes req_wdata[7:0] into the addressed lane.
  - Half: writes req_wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word: writes all four lanes.
  - Lanes not addressed are preserved.
- Load: extract the addressed byte or half, then sign-extend or zero-extend it to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- The access is performed on the edge that enters RESP. A load issued after a store's response returns the stored data.

## Timing
- Let cycle T be the cycle in which req_valid && req_ready is high.
- The access commits on the edge that ends cycle T+LATENCY.
- rsp_valid is first high in cycle T+LATENCY+1.
- If rsp_ready is high in the first RESP cycle, the state is IDLE in the next cycle, and the next request can be accepted there. Peak throughput is one request per LATENCY+2 cycles.
- Backpressure: RESP holds for any number of cycles, and the outputs stay constant while held.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0. req_ready reads 0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-operation:
  - In WAIT: the captured request is dropped and no store is committed.
  - In RESP: a store has already been committed and stays committed; the response is discarded.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0] = 1 sets rsp_err.
  - A word access with addr[1:0] != 0 sets rsp_err.
- DMEM_MISALIGN_TRAP_EN undefined:
  - The address is force-aligned: halves mask addr[0], words mask addr[1:0].
  - Misaligned accesses are never flagged. Only range errors and size errors raise rsp_err.

## Structure
- Shared package holds:
  - BIN_DIG.
  - Size encodings SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10.
  - FSM state enum dmem_state_t {IDLE, WAIT, RESP}.
- Sub-module dmem_lane_align: combinational. From size, lane, unsigned flag, stored word and write data it produces:
  - the merged write word,
  - the extended load value,
  - the misalign flag.
- The top level owns the FSM, the counter, the request capture registers and the array.

## Test plan
- Reset, then in the same config as each case below, store word 0x8765_4321 at 0x10 with LATENCY = 2. Required: rsp_valid rises in cycle T+3 with rsp_err = 0.
- Load byte at 0x13, signed, then unsigned. Required: rdata 0xFFFF_FF87, then 0x0000_0087.
- Store byte 0xAA at 0x11, then load word at 0x10. Required: 0x8765_AA21.
- Hold rsp_ready low for 5 cycles. Required: rsp_valid and rsp_rdata stable, req_ready 0. Then raise rsp_ready: next accept in the following cycle.
- Load a half at 0x11. Required: with DMEM_MISALIGN_TRAP_EN, rsp_err = 1 and rdata 0. Without it, rdata = zero- or sign-extended bytes 0x10..0x11.
- Store word to DEPTH_WORDS*4, and assert rst during WAIT of a store to 0x20. Required: the out-of-range store gives err = 1; a later load of 0x20 shows the old data; req_ready is 1 in the cycle after rst falls.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared widths, size encodings and FSM states for dmem_responder
package dmem_responder_pkg;

  localparam int BIN_DIG = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request and response channels between initiator and memory
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [BIN_DIG-1:0] req_addr;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic [BIN_DIG-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [BIN_DIG-1:0] rsp_rdata;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane merge, load extension and misalign detect (DMEM_MISALIGN_TRAP_EN)
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] wword,
  output logic [31:0] lval,
  output logic        misalign
);

  logic [1:0]  eff_lane;
  logic [4:0]  sh;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  // Pick the effective lane, then merge store data and extend load data around it.
  always_comb begin
    eff_lane = lane;
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((size == SIZE_H) && lane[0]) || ((size == SIZE_W) && (lane != 2'b00));
`else
    // Without trapping, halves and words silently drop the low address bits.
    if (size == SIZE_H) begin
      eff_lane = {lane[1], 1'b0};
    end else if (size == SIZE_W) begin
      eff_lane = 2'b00;
    end
`endif
    sh    = {eff_lane, 3'b000};
    bsel  = 8'(rword >> sh);
    hsel  = 16'(rword >> sh);
    wword = rword;
    lval  = '0;
    case (size)
      SIZE_B: begin
        wword = (rword & ~(32'h0000_00FF << sh)) | ({24'd0, wdata[7:0]} << sh);
        lval  = is_unsigned ? {24'd0, bsel} : {{24{bsel[7]}}, bsel};
      end
      SIZE_H: begin
        wword = (rword & ~(32'h0000_FFFF << sh)) | ({16'd0, wdata[15:0]} << sh);
        lval  = is_unsigned ? {16'd0, hsel} : {{16{hsel[15]}}, hsel};
      end
      SIZE_W: begin
        wword = wdata;
        lval  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-configurable data-memory responder; misalign trap via DMEM_MISALIGN_TRAP_EN
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int                 AW       = $clog2(DEPTH_WORDS);
  localparam logic [BIN_DIG-1:0] BYTE_CAP = BIN_DIG'(DEPTH_WORDS * 4);
  localparam logic [3:0]         LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_t        state, state_nxt;
  logic [3:0]         cnt;
  logic               cap_we, cap_uns;
  logic [1:0]         cap_size;
  logic [BIN_DIG-1:0] cap_addr, cap_wdata;
  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;
  logic               accept, do_access;

  logic               acc_we, acc_uns;
  logic [1:0]         acc_size;
  logic [BIN_DIG-1:0] acc_addr, acc_wdata;
  logic [AW-1:0]      word_idx;
  logic [31:0]        wword, lval;
  logic               misalign, acc_err;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake outputs and the access strobe.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    accept        = 1'b0;
    do_access     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid && !rst) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            do_access = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk) begin
    if (rst)                                cnt <= 4'd0;
    else if (accept)                        cnt <= LAT_LOAD;
    else if (state == WAIT && cnt != 4'd0)  cnt <= cnt - 4'd1;
  end

  // Request capture; zero latency accesses use the live fields instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= bus.req_we;
      cap_addr  <= bus.req_addr;
      cap_size  <= bus.req_size;
      cap_uns   <= bus.req_unsigned;
      cap_wdata <= bus.req_wdata;
    end
  end

  // Access operands: live request when accessing from IDLE, captured request otherwise.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_size  = bus.req_size;
      acc_uns   = bus.req_unsigned;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_we    = cap_we;
      acc_addr  = cap_addr;
      acc_size  = cap_size;
      acc_uns   = cap_uns;
      acc_wdata = cap_wdata;
    end
    word_idx = acc_addr[AW+1:2];
    acc_err  = (acc_addr >= BYTE_CAP) || (acc_size == 2'b11) || misalign;
  end

  dmem_lane_align u_lane_align (
    .size        (acc_size),
    .lane        (acc_addr[1:0]),
    .is_unsigned (acc_uns),
    .rword       (mem[word_idx]),
    .wdata       (acc_wdata),
    .wword       (wword),
    .lval        (lval),
    .misalign    (misalign)
  );

  // Array write on the edge entering RESP; reset in WAIT suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_we && !acc_err) mem[word_idx] <= wword;
  end

  // Response registers, held constant for the whole RESP stay.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (do_access) begin
      rsp_rdata_q <= (acc_we || acc_err) ? 32'd0 : lval;
      rsp_err_q   <= acc_err;
    end
  end

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
